systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Sequencer for a 1-D systolic chain of N MAC cells; each cell forwards data to its neighbour and accumulates a partial sum from its predecessor.
- On a start request it clears the chain, streams LEN input vectors from the input buffer, and generates a per-lane skewed valid.
- It drains the pipeline, issues result-buffer writes and signals completion.
- It sits between the top-level command interface and the MAC chain / SRAM buffers.

Parameters:
- N, 4, number of MAC lanes in the chain (N >= 1)
- LEN_W, 8, width of the vector-count and buffer-address fields

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_len  in  LEN_W  number of input vectors; latched when start is accepted
- o_busy  out  1  high from CLEAR through DONE inclusive
- o_done  out  1  one-cycle completion pulse (DONE state)
- o_clr  out  1  one-cycle clear of MAC accumulators and forwarding regs
- o_rd_en  out  1  input-buffer read enable
- o_rd_addr  out  LEN_W  input-buffer read address
- o_lane_en  out  N  per-lane data-valid, skewed by lane index
- o_wr_en  out  1  result-buffer write enable
- o_wr_addr  out  LEN_W  result-buffer write address

Behaviour:
- Interface: one clock (i_clk); i_rst is asynchronous and active-high. While i_rst is high, all outputs are 0, state is IDLE, and counters and shift registers are 0.
- All outputs are registered.
- Reset mid-operation aborts immediately with no done pulse. After release the block is in IDLE.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - If i_start=1 at a clock edge, latch i_len into len_q.
  - If i_len != 0, go to CLEAR.
  - If i_len == 0, go directly to DONE; no clear, no reads, no writes.
- CLEAR: o_clr=1 for exactly one cycle, then go to FEED.
- FEED:
  - o_rd_en=1 for exactly len_q cycles.
  - o_rd_addr = 0, 1, …, len_q-1, incrementing each FEED cycle.
  - Go to DRAIN after the last read.
- Lane skew:
  - Input-buffer read latency is 1 cycle.
  - o_lane_en[0] = o_rd_en delayed 1 cycle.
  - o_lane_en[r] = o_lane_en[r-1] delayed 1 cycle.
- Write path:
  - MAC latency is 1 cycle, so o_wr_en = o_lane_en[N-1] delayed 1 cycle.
  - o_wr_addr starts at 0 and increments after each o_wr_en cycle.
- DRAIN:
  - Drain counter lasts exactly N+1 cycles; the last cycle coincides with the final o_wr_en.
  - Then go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy falls with the return to IDLE.
- Timing reference: start accepted at edge of cycle 0, L=len_q.
  - CLEAR: cycle 1
  - FEED: cycles 2..L+1
  - o_lane_en[r]: cycles 3+r..L+2+r
  - o_wr_en: cycles N+3..L+N+2
  - DRAIN: cycles L+2..L+N+2
  - DONE: cycle L+N+3
  - Earliest next accept: edge ending cycle L+N+4 (back in IDLE).
- Total busy cycles = L+N+3 (L>0); = 1 for L=0.
- i_start while busy (not IDLE) is ignored, not queued. i_len changes while busy have no effect.
- Counters never wrap within a job. L = 2^LEN_W - 1 is the maximum job, addresses 0..2^LEN_W-2.
- Exactly L write pulses per job; the counts of o_rd_en, each o_lane_en[r] and o_wr_en pulses are all equal to L.

Test Plan:
- Reset/idle: assert i_rst mid-cycle with no clock edge -> all outputs 0 immediately. Hold i_start=0 for 20 cycles after release -> outputs stay 0.
- Basic job, N=4, i_len=3, start at cycle 0:
  - o_clr at cycle 1
  - o_rd_en cycles 2–4, addresses 0,1,2
  - o_lane_en[0] cycles 3–5, o_lane_en[3] cycles 6–8
  - o_wr_en cycles 7–9, addresses 0,1,2
  - o_done at cycle 10; o_busy cycles 1–10
- Zero length: i_len=0 -> o_done at cycle 1; o_busy high 1 cycle; no o_clr, no o_rd_en, no o_wr_en.
- Start while busy: during the i_len=3 job, pulse i_start with i_len=9 at cycles 2 and 10 -> still exactly 3 writes, done at cycle 10. Start held high through cycle 11 -> second job (len 9) with CLEAR at cycle 12.
- Max length: i_len=255 -> 255 reads with addresses 0..254, 255 writes, o_done exactly 1 cycle at cycle 262; no address wrap.
- Reset mid-operation: assert i_rst at cycle 5 of the L=3 job -> outputs 0 asynchronously, no o_done. New start after release -> full correct job from address 0.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 1-D systolic MAC chain: clears the chain, streams the input vectors with a
// per-lane skewed valid, drains the pipeline into the result buffer and reports completion.
`timescale 1ns/1ps

module systolic_seq_ctrl #(
    parameter int unsigned N     = 32'd4,
    parameter int unsigned LEN_W = 32'd8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_clr,
    output logic             o_rd_en,
    output logic [LEN_W-1:0] o_rd_addr,
    output logic [N-1:0]     o_lane_en,
    output logic             o_wr_en,
    output logic [LEN_W-1:0] o_wr_addr
);

    // Drain counter runs 0..N, so it must hold the value N.
    localparam int unsigned DRN_W = $clog2(N + 32'd2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_nxt_s;
    logic [DRN_W-1:0]   drn_r;
    logic [DRN_W-1:0]   drn_nxt_s;
    logic [LEN_W-1:0]   rd_addr_nxt_s;
    logic [LEN_W-1:0]   wr_addr_nxt_s;
    logic [N-1:0]       lane_nxt_s;

    // Lane 0 follows the read enable (one-cycle buffer latency); each later lane follows its predecessor.
    generate
        if (N == 32'd1) begin : g_lane_single
            assign lane_nxt_s = o_rd_en;
        end else begin : g_lane_chain
            assign lane_nxt_s = {o_lane_en[N-2:0], o_rd_en};
        end
    endgenerate

    // Next-state, job length, drain count and read-address sequencing.
    always_comb begin
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        drn_nxt_s     = {DRN_W{1'b0}};
        rd_addr_nxt_s = {LEN_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    len_nxt_s = i_len;
                    if (i_len != {LEN_W{1'b0}}) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_FEED;
            end
            ST_FEED: begin
                if (o_rd_addr == (len_r - LEN_W'(1'b1))) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s   = ST_FEED;
                    rd_addr_nxt_s = o_rd_addr + LEN_W'(1'b1);
                end
            end
            ST_DRAIN: begin
                // The last drain cycle carries the final result write.
                if (drn_r == DRN_W'(N)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                    drn_nxt_s   = drn_r + DRN_W'(1'b1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result address advances after every write and restarts at zero for each job.
    always_comb begin
        wr_addr_nxt_s = {LEN_W{1'b0}};
        if ((state_nxt_s == ST_FEED) || (state_nxt_s == ST_DRAIN)) begin
            if (o_wr_en) begin
                wr_addr_nxt_s = o_wr_addr + LEN_W'(1'b1);
            end else begin
                wr_addr_nxt_s = o_wr_addr;
            end
        end else begin
            wr_addr_nxt_s = {LEN_W{1'b0}};
        end
    end

    // State, counters and registered outputs; reset aborts any job without a done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            len_r     <= {LEN_W{1'b0}};
            drn_r     <= {DRN_W{1'b0}};
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_clr     <= 1'b0;
            o_rd_en   <= 1'b0;
            o_rd_addr <= {LEN_W{1'b0}};
            o_lane_en <= {N{1'b0}};
            o_wr_en   <= 1'b0;
            o_wr_addr <= {LEN_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            len_r     <= len_nxt_s;
            drn_r     <= drn_nxt_s;
            o_busy    <= (state_nxt_s != ST_IDLE);
            o_done    <= (state_nxt_s == ST_DONE);
            o_clr     <= (state_nxt_s == ST_CLEAR);
            o_rd_en   <= (state_nxt_s == ST_FEED);
            o_rd_addr <= rd_addr_nxt_s;
            o_lane_en <= lane_nxt_s;
            o_wr_en   <= o_lane_en[N-1];
            o_wr_addr <= wr_addr_nxt_s;
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed scenarios plus randomized back-to-back jobs, all
// cross-checked every cycle against a cycle-window model of a job.
`timescale 1ns/1ps

module tb_systolic_seq_ctrl;

    localparam int N     = 4;
    localparam int LEN_W = 8;
    localparam int OW    = 2 * LEN_W + N + 5;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic             busy, done, clr, rd_en, wr_en;
    logic [LEN_W-1:0] rd_addr, wr_addr;
    logic [N-1:0]     lane_en;
    logic [OW-1:0]    all_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycle index and the currently accepted job.
    int cyc    = 0;
    bit m_has  = 1'b0;
    int m_acc  = 0;
    int m_len  = 0;
    bit mon_en = 1'b0;

    systolic_seq_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_len     (len),
        .o_busy    (busy),
        .o_done    (done),
        .o_clr     (clr),
        .o_rd_en   (rd_en),
        .o_rd_addr (rd_addr),
        .o_lane_en (lane_en),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr)
    );

    assign all_out = {busy, done, clr, rd_en, wr_en, rd_addr, wr_addr, lane_en};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int span_of(input int l);
        return (l == 0) ? 1 : l + N + 3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_has <= 1'b0;
        end else if ((!m_has || (cyc - m_acc) > span_of(m_len)) && start) begin
            m_has <= 1'b1;
            m_acc <= cyc;
            m_len <= int'(len);
        end
    end

    // Advance one cycle; at the falling edge compare all outputs with the job-window model.
    task automatic tick();
        int k;
        logic eb, ed, ec, er, ew;
        logic [N-1:0] el;
        @(negedge clk);
        if (!rst && mon_en) begin
            k  = m_has ? (cyc - m_acc) : -1000;
            eb = 1'b0; ed = 1'b0; ec = 1'b0; er = 1'b0; ew = 1'b0; el = '0;
            if (m_len == 0) begin
                eb = (k == 1);
                ed = (k == 1);
            end else begin
                eb = (k >= 1) && (k <= m_len + N + 3);
                ed = (k == m_len + N + 3);
                ec = (k == 1);
                er = (k >= 2) && (k <= m_len + 1);
                ew = (k >= N + 3) && (k <= m_len + N + 2);
                for (int r = 0; r < N; r++) el[r] = (k >= 3 + r) && (k <= m_len + 2 + r);
            end
            checks++;
            if ({busy, done, clr, rd_en, wr_en} !== {eb, ed, ec, er, ew}) begin
                errors++;
                $display("FAIL model_ctrl cyc=%0d got busy/done/clr/rd/wr=%b expected=%b",
                         cyc, {busy, done, clr, rd_en, wr_en}, {eb, ed, ec, er, ew});
            end
            checks++;
            if (lane_en !== el) begin
                errors++;
                $display("FAIL model_lane cyc=%0d got=%b expected=%b", cyc, lane_en, el);
            end
            if (er) begin
                checks++;
                if (rd_addr !== LEN_W'(k - 2)) begin
                    errors++;
                    $display("FAIL model_rd_addr cyc=%0d got=%0d expected=%0d", cyc, rd_addr, k - 2);
                end
            end
            if (ew) begin
                checks++;
                if (wr_addr !== LEN_W'(k - N - 3)) begin
                    errors++;
                    $display("FAIL model_wr_addr cyc=%0d got=%0d expected=%0d", cyc, wr_addr, k - N - 3);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int l, output int a);
        start = 1'b1;
        len   = LEN_W'(l);
        a     = cyc;
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== OW'(0)) begin
            errors++;
            $display("FAIL reset_async got=%0h expected=0", all_out);
        end
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (all_out !== OW'(0)) begin
                errors++;
                $display("FAIL idle_hold cycle=%0d got=%0h expected=0", i, all_out);
            end
        end
    endtask

    task automatic test_basic();
        int a, k;
        logic [N-1:0] el;
        launch(3, a);
        for (int i = 0; i < 13; i++) begin
            k  = cyc - a;
            el = {1'((k >= 6) && (k <= 8)), 1'((k >= 5) && (k <= 7)),
                  1'((k >= 4) && (k <= 6)), 1'((k >= 3) && (k <= 5))};
            checks++;
            if (busy !== 1'((k >= 1) && (k <= 10))) begin
                errors++; $display("FAIL basic_busy k=%0d got=%b", k, busy);
            end
            checks++;
            if (done !== 1'(k == 10)) begin
                errors++; $display("FAIL basic_done k=%0d got=%b", k, done);
            end
            checks++;
            if (clr !== 1'(k == 1)) begin
                errors++; $display("FAIL basic_clr k=%0d got=%b", k, clr);
            end
            checks++;
            if (rd_en !== 1'((k >= 2) && (k <= 4))) begin
                errors++; $display("FAIL basic_rd_en k=%0d got=%b", k, rd_en);
            end
            checks++;
            if (lane_en !== el) begin
                errors++; $display("FAIL basic_lane k=%0d got=%b expected=%b", k, lane_en, el);
            end
            checks++;
            if (wr_en !== 1'((k >= 7) && (k <= 9))) begin
                errors++; $display("FAIL basic_wr_en k=%0d got=%b", k, wr_en);
            end
            if (rd_en) begin
                checks++;
                if (rd_addr !== LEN_W'(k - 2)) begin
                    errors++; $display("FAIL basic_rd_addr k=%0d got=%0d expected=%0d", k, rd_addr, k - 2);
                end
            end
            if (wr_en) begin
                checks++;
                if (wr_addr !== LEN_W'(k - 7)) begin
                    errors++; $display("FAIL basic_wr_addr k=%0d got=%0d expected=%0d", k, wr_addr, k - 7);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_len();
        int a, k;
        launch(0, a);
        for (int i = 0; i < 3; i++) begin
            k = cyc - a;
            checks++;
            if ({busy, done} !== {1'(k == 1), 1'(k == 1)}) begin
                errors++; $display("FAIL zero_busy_done k=%0d got=%b", k, {busy, done});
            end
            checks++;
            if ({clr, rd_en, wr_en, lane_en} !== '0) begin
                errors++; $display("FAIL zero_quiet k=%0d got=%b expected=0", k, {clr, rd_en, wr_en, lane_en});
            end
            tick();
        end
    endtask

    task automatic test_start_while_busy();
        int a, k, nwr1, nwr2, done_k, clr2_k;
        nwr1 = 0; nwr2 = 0; done_k = -1; clr2_k = -1;
        launch(3, a);
        while ((cyc - a) <= 40) begin
            k = cyc - a;
            start = ((k == 2) || (k == 10) || (k == 11)) ? 1'b1 : 1'b0;
            len   = LEN_W'(9);
            if (wr_en && k <= 11) nwr1++;
            if (wr_en && k >= 12) nwr2++;
            if (done && done_k < 0) done_k = k;
            if (clr && k > 1 && clr2_k < 0) clr2_k = k;
            tick();
        end
        start = 1'b0;
        checks++;
        if (nwr1 !== 3) begin errors++; $display("FAIL busy_start_writes got=%0d expected=3", nwr1); end
        checks++;
        if (done_k !== 10) begin errors++; $display("FAIL busy_start_done got=%0d expected=10", done_k); end
        checks++;
        if (clr2_k !== 12) begin errors++; $display("FAIL busy_start_clr2 got=%0d expected=12", clr2_k); end
        checks++;
        if (nwr2 !== 9) begin errors++; $display("FAIL busy_start_job2_writes got=%0d expected=9", nwr2); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b expected=0", busy); end
    endtask

    task automatic test_max_len();
        int a, k, nrd, nwr, ndone, done_k;
        nrd = 0; nwr = 0; ndone = 0; done_k = -1;
        launch(255, a);
        while ((cyc - a) <= 265) begin
            k = cyc - a;
            if (rd_en) begin
                checks++;
                if (rd_addr !== LEN_W'(nrd)) begin
                    errors++; $display("FAIL max_rd_addr got=%0d expected=%0d", rd_addr, nrd);
                end
                nrd++;
            end
            if (wr_en) begin
                checks++;
                if (wr_addr !== LEN_W'(nwr)) begin
                    errors++; $display("FAIL max_wr_addr got=%0d expected=%0d", wr_addr, nwr);
                end
                nwr++;
            end
            if (done) begin ndone++; done_k = k; end
            tick();
        end
        checks++;
        if (nrd !== 255) begin errors++; $display("FAIL max_reads got=%0d expected=255", nrd); end
        checks++;
        if (nwr !== 255) begin errors++; $display("FAIL max_writes got=%0d expected=255", nwr); end
        checks++;
        if ({ndone, done_k} !== {32'sd1, 32'sd262}) begin
            errors++; $display("FAIL max_done count=%0d at=%0d expected 1 at 262", ndone, done_k);
        end
    endtask

    task automatic test_reset_mid();
        int a, k, ndone, first_rd_k, first_rd_addr, done_k;
        ndone = 0; first_rd_k = -1; first_rd_addr = -1; done_k = -1;
        launch(3, a);
        while ((cyc - a) < 5) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got=%b expected=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== OW'(0)) begin errors++; $display("FAIL rst_mid_async got=%0h expected=0", all_out); end
        repeat (2) begin
            tick();
            if (done) ndone++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d expected=0", ndone); end
        checks++;
        if (all_out !== OW'(0)) begin errors++; $display("FAIL rst_mid_idle got=%0h expected=0", all_out); end
        launch(3, a);
        for (int i = 0; i < 12; i++) begin
            k = cyc - a;
            if (rd_en && first_rd_k < 0) begin first_rd_k = k; first_rd_addr = int'(rd_addr); end
            if (done) done_k = k;
            tick();
        end
        checks++;
        if ({first_rd_k, first_rd_addr} !== {32'sd2, 32'sd0}) begin
            errors++; $display("FAIL rst_mid_restart_rd at=%0d addr=%0d expected 2/0", first_rd_k, first_rd_addr);
        end
        checks++;
        if (done_k !== 10) begin errors++; $display("FAIL rst_mid_restart_done got=%0d expected=10", done_k); end
    endtask

    task automatic test_back_to_back();
        int a, k, l, span, nrd, nwr, ndone;
        for (int j = 0; j < 10; j++) begin
            l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            span = span_of(l);
            nrd = 0; nwr = 0; ndone = 0;
            launch(l, a);
            while ((cyc - a) <= span) begin
                k = cyc - a;
                start = 1'($urandom_range(0, 1));
                len   = LEN_W'($urandom);
                if (rd_en) nrd++;
                if (wr_en) nwr++;
                if (done) ndone++;
                tick();
            end
            start = 1'b0;
            checks++;
            if ({nrd, nwr, ndone} !== {l, l, 32'sd1}) begin
                errors++;
                $display("FAIL b2b_counts job=%0d len=%0d reads=%0d writes=%0d dones=%0d", j, l, nrd, nwr, ndone);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle job=%0d got=%b expected=0", j, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        repeat (2) tick();
        test_zero_len();
        test_start_while_busy();
        repeat (2) tick();
        test_max_len();
        test_reset_mid();
        repeat (2) tick();
        test_back_to_back();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
